led_sequencer: RTL and testbench

Parametrised LED pattern generator, the next generation of the board's single-LED bounce block. It drives an N-wide LED bank from the system clock with four runtime-selectable patterns: bounce, rotate-left, rotate-right and bar-fill. It also provides a speed select, a run/hold control and an end-of-sweep pulse. It sits directly between the top-level clock and the board LED pins.

---
 rtl/led_seq_pkg.sv | 12 +
 rtl/led_seq_prescaler.sv | 35 +++
 rtl/led_sequencer.sv | 164 ++++++++++++++++
 tb/tb_led_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and defaults for the LED pattern sequencer.
package led_seq_pkg;
  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_ROTL   = 2'd1,
    MODE_ROTR   = 2'd2,
    MODE_FILL   = 2'd3
  } mode_e;

  localparam int N_LEDS_DEF   = 8;
  localparam int TICK_DIV_DEF = 12_500_000;
endpackage

// File: rtl/led_seq_prescaler.sv
// Step-rate prescaler: period = max(1, TICK_DIV >> speed) cycles.
module led_seq_prescaler
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int SPEED_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [SPEED_W-1:0] speed,
  input  logic               clear,
  output logic               tick
);
  localparam int CW = $clog2(TICK_DIV + 1);
  localparam logic [CW-1:0] DIV = CW'(TICK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] shifted, limit;

  // >= so that a speed-up below the current count ticks at once
  always_comb begin
    shifted = DIV >> speed;
    limit   = (shifted == '0) ? CW'(1) : shifted;
    tick    = run && !clear && (cnt_q >= limit - CW'(1));
    cnt_d   = cnt_q;
    if (clear || tick) cnt_d = '0;
    else if (run)      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/led_sequencer.sv
// N-wide LED pattern generator: bounce, rotate-left/right, bar-fill.
// Optional trail on BOUNCE/ROT patterns when LED_SEQ_TRAIL_EN is defined.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int N_LEDS   = N_LEDS_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int SPEED_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic [SPEED_W-1:0] speed,
  input  logic               run,
  output logic [N_LEDS-1:0]  leds,
  output logic               dir,
  output logic               wrap_pulse
);
  localparam int LW = $clog2(N_LEDS + 1);
  localparam logic [N_LEDS-1:0] LSB = N_LEDS'(1);
  localparam logic [N_LEDS-1:0] MSB = LSB << (N_LEDS - 1);

  mode_e             mode_q, mode_d;
  logic [N_LEDS-1:0] cur_q, cur_d;
  logic [LW-1:0]     level_q, level_d;
  logic              dir_q, dir_d;
  logic              wrap_q, wrap_d;
  logic              tick, reload;

  function automatic logic [N_LEDS-1:0] start_pat(mode_e m);
    unique case (m)
      MODE_ROTR: start_pat = MSB;
      MODE_FILL: start_pat = '0;
      default:   start_pat = LSB;
    endcase
  endfunction

  function automatic logic [N_LEDS-1:0] fill_mask(logic [LW-1:0] lv);
    for (int i = 0; i < N_LEDS; i++) fill_mask[i] = (LW'(i) < lv);
  endfunction

  function automatic logic is_onehot(logic [N_LEDS-1:0] v);
    is_onehot = (v != '0) && ((v & (v - LSB)) == '0);
  endfunction

  assign mode_d = mode_e'(mode);
  assign reload = (mode_d != mode_q);

  led_seq_prescaler #(
    .TICK_DIV (TICK_DIV),
    .SPEED_W  (SPEED_W)
  ) u_presc (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .speed (speed),
    .clear (reload),
    .tick  (tick)
  );

  always_comb begin
    logic [N_LEDS-1:0] nxt;
    logic [LW-1:0]     lv;
    nxt     = '0;
    lv      = '0;
    cur_d   = cur_q;
    level_d = level_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    if (reload) begin
      cur_d   = start_pat(mode_d);
      dir_d   = (mode_d != MODE_ROTR);
      level_d = '0;
    end else if (tick) begin
      if (mode_q == MODE_FILL) begin
        lv      = dir_q ? level_q + LW'(1) : level_q - LW'(1);
        level_d = lv;
        cur_d   = fill_mask(lv);
        if (lv == LW'(N_LEDS) || lv == '0) begin
          dir_d  = !dir_q;
          wrap_d = 1'b1;
        end
      end else if (!is_onehot(cur_q)) begin
        cur_d = start_pat(mode_q);
        dir_d = (mode_q != MODE_ROTR);
      end else begin
        unique case (mode_q)
          MODE_BOUNCE: begin
            nxt   = dir_q ? cur_q << 1 : cur_q >> 1;
            cur_d = nxt;
            if (nxt == MSB || nxt == LSB) begin
              dir_d  = !dir_q;
              wrap_d = 1'b1;
            end
          end
          MODE_ROTL: begin
            nxt    = {cur_q[N_LEDS-2:0], cur_q[N_LEDS-1]};
            cur_d  = nxt;
            wrap_d = (nxt == LSB);
          end
          MODE_ROTR: begin
            nxt    = {cur_q[0], cur_q[N_LEDS-1:1]};
            cur_d  = nxt;
            wrap_d = (nxt == MSB);
          end
          MODE_FILL: begin
            cur_d = cur_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_BOUNCE;
      cur_q   <= LSB;
      level_q <= '0;
      dir_q   <= 1'b1;
      wrap_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      cur_q   <= cur_d;
      level_q <= level_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
    end
  end

  assign dir        = dir_q;
  assign wrap_pulse = wrap_q;

`ifdef LED_SEQ_TRAIL_EN
  logic [N_LEDS-1:0] prev_q, prev_d;
  logic [N_LEDS-1:0] leds_q, leds_d;
  logic [1:0]        duty_q, duty_d;

  // prev holds the LED lit before the last step; shown 1 cycle in 4
  always_comb begin
    duty_d = duty_q + 2'd1;
    prev_d = prev_q;
    if (reload)                         prev_d = '0;
    else if (tick && mode_q != MODE_FILL) prev_d = cur_q;
    if (mode_d == MODE_FILL) leds_d = cur_d;
    else leds_d = cur_d | (prev_d & {N_LEDS{duty_d == 2'd0}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      leds_q <= LSB;
      duty_q <= 2'd0;
    end else begin
      prev_q <= prev_d;
      leds_q <= leds_d;
      duty_q <= duty_d;
    end
  end

  assign leds = leds_q;
`else
  assign leds = cur_q;
`endif
endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer (N_LEDS=8, TICK_DIV=4).
module tb_led_sequencer;
  localparam int N  = 8;
  localparam int TD = 4;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic [SW-1:0] speed;
  logic          run;
  logic [N-1:0]  leds;
  logic          dir;
  logic          wrap_pulse;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  led_sequencer #(
    .N_LEDS   (N),
    .TICK_DIV (TD),
    .SPEED_W  (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .speed      (speed),
    .run        (run),
    .leds       (leds),
    .dir        (dir),
    .wrap_pulse (wrap_pulse)
  );

  always #5 clk = ~clk;

  // Pattern as a function of steps taken since the last reload
  function automatic logic [N-1:0] pat(int m, int k);
    int r, p;
    case (m)
      0: begin
        r = k % (2*N-2);
        p = (r <= N-1) ? r : (2*N-2) - r;
        return N'(1 << p);
      end
      1: return N'(1 << (k % N));
      2: return N'((1 << (N-1)) >> (k % N));
      default: begin
        r = k % (2*N);
        p = (r <= N) ? r : 2*N - r;
        return N'((1 << p) - 1);
      end
    endcase
  endfunction

  function automatic logic dir_of(int m, int k);
    case (m)
      0: return (k % (2*N-2)) < N-1;
      1: return 1'b1;
      2: return 1'b0;
      default: return (k % (2*N)) < N;
    endcase
  endfunction

  function automatic logic wrap_of(int m, int k);
    int r;
    if (k == 0) return 1'b0;
    case (m)
      0: begin r = k % (2*N-2); return r == N-1 || r == 0; end
      1, 2: return (k % N) == 0;
      default: begin r = k % (2*N); return r == N || r == 0; end
    endcase
  endfunction

  int m_mode, m_k, m_cnt, m_lim;
  logic m_wrap;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_k = 0; m_cnt = 0; m_wrap = 1'b0;
    end else if (int'(mode) != m_mode) begin
      m_mode = int'(mode); m_k = 0; m_cnt = 0; m_wrap = 1'b0;
    end else if (run) begin
      m_lim = TD >> speed;
      if (m_lim < 1) m_lim = 1;
      if (m_cnt >= m_lim - 1) begin
        m_cnt = 0;
        m_k++;
        m_wrap = wrap_of(m_mode, m_k);
      end else begin
        m_cnt++;
        m_wrap = 1'b0;
      end
    end else begin
      m_wrap = 1'b0;
    end
  end

  task automatic chk(string nm, logic [N-1:0] got, logic [N-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [N-1:0] e, p;
      e = pat(m_mode, m_k);
      p = (m_k > 0 && m_mode != 3) ? pat(m_mode, m_k - 1) : '0;
`ifdef LED_SEQ_TRAIL_EN
      total++;
      if (leds !== e && leds !== (e | p)) begin
        bad++;
        $display("FAIL model_leds got=%h exp=%h|%h t=%0t", leds, e, p, $time);
      end
`else
      chk("model_leds", leds, e);
`endif
      chk("model_dir", N'(dir), N'(dir_of(m_mode, m_k)));
      chk("model_wrap", N'(wrap_pulse), N'(m_wrap));
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n06;
    rst = 1'b1; mode = 2'd0; speed = '0; run = 1'b1;
    cyc(2);
    chk_en = 1'b1;
    chk("rst_leds", leds, 8'h01);
    chk("rst_dir", N'(dir), N'(1));
    chk("rst_wrap", N'(wrap_pulse), N'(0));
    rst = 1'b0;
    cyc(3);  chk("pre_step", leds, 8'h01);
    cyc(1);  chk("edge4", leds, 8'h02);
    cyc(24); chk("msb", leds, 8'h80);
    chk("msb_wrap", N'(wrap_pulse), N'(1));
    chk("msb_dir", N'(dir), N'(0));
    cyc(4);  chk("after_msb", leds, 8'h40);
    chk("after_msb_wrap", N'(wrap_pulse), N'(0));
    cyc(24); chk("lsb", leds, 8'h01);
    chk("lsb_wrap", N'(wrap_pulse), N'(1));
    chk("lsb_dir", N'(dir), N'(1));
    // hold at cnt=2
    cyc(2);  run = 1'b0;
    cyc(10); chk("hold", leds, 8'h01);
    run = 1'b1;
    cyc(1);  chk("resume1", leds, 8'h01);
    cyc(1);  chk("resume2", leds, 8'h02);
    speed = 3'd1;
    cyc(1);  chk("spd1_a", leds, 8'h02);
    cyc(1);  chk("spd1_b", leds, 8'h04);
    speed = 3'd2;
    cyc(1);  chk("spd2", leds, 8'h08);
    speed = 3'd7;
    cyc(1);  chk("spd7", leds, 8'h10);
    speed = 3'd0;
    cyc(3);  speed = 3'd2;
    cyc(1);  chk("speedup_cnt3", leds, 8'h20);
    speed = 3'd0;
    cyc(2);  speed = 3'd1;
    cyc(1);  chk("speedup_cnt2", leds, 8'h40);
    speed = 3'd0;
    // ROTR
    mode = 2'd2;
    cyc(1);  chk("rotr_load", leds, 8'h80);
    chk("rotr_dir", N'(dir), N'(0));
    chk("rotr_nowrap", N'(wrap_pulse), N'(0));
    cyc(4);  chk("rotr_1", leds, 8'h40);
    cyc(24); chk("rotr_7", leds, 8'h01);
    cyc(4);  chk("rotr_wrap_led", leds, 8'h80);
    chk("rotr_wrap", N'(wrap_pulse), N'(1));
    cyc(1);  chk("rotr_wrap_end", N'(wrap_pulse), N'(0));
    // FILL
    mode = 2'd3;
    cyc(1);  chk("fill_load", leds, 8'h00);
    chk("fill_dir", N'(dir), N'(1));
    cyc(4);  chk("fill_1", leds, 8'h01);
    cyc(4);  chk("fill_2", leds, 8'h03);
    cyc(24); chk("fill_full", leds, 8'hFF);
    chk("fill_full_wrap", N'(wrap_pulse), N'(1));
    chk("fill_full_dir", N'(dir), N'(0));
    cyc(4);  chk("fill_7f", leds, 8'h7F);
    cyc(28); chk("fill_empty", leds, 8'h00);
    chk("fill_empty_wrap", N'(wrap_pulse), N'(1));
    // reload while held
    run = 1'b0; mode = 2'd1;
    cyc(1);  chk("rotl_load_hold", leds, 8'h01);
    run = 1'b1;
    cyc(40); chk("rotl_k10", leds, 8'h04);
    cyc(3);  mode = 2'd0;
    cyc(1);  chk("reload_wins", leds, 8'h01);
    chk("reload_nowrap", N'(wrap_pulse), N'(0));
    cyc(20); chk("bounce_k5", leds, 8'h20);
    // async reset between edges
    #2 rst = 1'b1;
    #1 chk("async_leds", leds, 8'h01);
    chk("async_dir", N'(dir), N'(1));
    @(negedge clk) rst = 1'b0;
    cyc(7);
    n06 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (leds === 8'h06) n06++;
    end
`ifdef LED_SEQ_TRAIL_EN
    chk("trail_count", N'(n06), N'(1));
`else
    chk("trail_count", N'(n06), N'(0));
`endif
    chk("trail_end", leds & 8'hFB, 8'h00);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
